// File: rtl/player_motion_if.sv
// Controller/frame inputs and sprite-state outputs of one player_motion instance.
interface player_motion_if;
    logic       frame_tick;
    logic [7:0] buttons;
    logic [9:0] char_x;
    logic [9:0] char_y;
    logic       facing_right;
    logic [9:0] anim_row;
    logic [9:0] anim_col;
    logic       on_ground;

    modport master (
        output frame_tick, buttons,
        input  char_x, char_y, facing_right, anim_row, anim_col, on_ground
    );

    modport slave (
        input  frame_tick, buttons,
        output char_x, char_y, facing_right, anim_row, anim_col, on_ground
    );
endinterface

// File: rtl/player_motion.sv
// Per-player walk/jump/gravity engine with walk-cycle animation, updated once per frame.
// Define PLATFORM_COLLIDE_EN to enable landing on and standing on the platform.
module player_motion #(
    parameter int X_INIT    = 0,
    parameter int Y_INIT    = 0,
    parameter int X_MAX     = 610,
    parameter int GROUND_Y  = 440,
    parameter int WALK_STEP = 5,
    parameter int JUMP_VEL  = 12,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 10,
    parameter int CHAR_W    = 46,
    parameter int CHAR_H    = 60,
    parameter int PLT_X     = 100,
    parameter int PLT_Y     = 410,
    parameter int PLT_W     = 100,
    parameter int ANIM_DIV  = 4
) (
    input logic            clk,
    input logic            rst_n,
    player_motion_if.slave bus
);

`ifdef PLATFORM_COLLIDE_EN
    localparam bit PLAT_EN = 1'b1;
`else
    localparam bit PLAT_EN = 1'b0;
`endif

    localparam logic signed [10:0] GROUND_S  = 11'(GROUND_Y);
    localparam logic signed [10:0] PLT_TOP_S = 11'(PLT_Y - CHAR_H);
    localparam logic signed [10:0] Y_INIT_S  = 11'(Y_INIT);
    localparam logic signed [5:0]  JUMP_S    = 6'(-JUMP_VEL);
    localparam logic signed [5:0]  GRAV_S    = 6'(GRAVITY);
    localparam logic signed [5:0]  MAXF_S    = 6'(MAX_FALL);
    localparam logic [10:0]        X_MAX_U   = 11'(X_MAX);
    localparam logic [10:0]        STEP_U    = 11'(WALK_STEP);
    localparam logic [10:0]        CHAR_W_U  = 11'(CHAR_W);
    localparam logic [10:0]        PLT_L_U   = 11'(PLT_X);
    localparam logic [10:0]        PLT_R_U   = 11'(PLT_X + PLT_W);
    localparam logic [7:0]         DIV_LAST  = 8'(ANIM_DIV - 1);

    typedef enum logic [1:0] {StIdle, StWalk, StAir} state_e;

    state_e             state_q, state_d;
    logic               frame_q;
    logic               upd;
    logic [9:0]         x_q, x_d;
    logic signed [10:0] y_q, y_d;
    logic signed [5:0]  vel_q, vel_d;
    logic               facing_q, facing_d;
    logic [2:0]         f_q, f_d;
    logic [7:0]         div_q, div_d;
    logic [9:0]         row_q, row_d;
    logic [9:0]         col_q, col_d;

    logic               right, left, up;
    logic [10:0]        x_wide;
    logic [9:0]         x_mv;
    logic               face_mv;
    logic               overlap;
    logic               supported;
    state_e             gnd_state;
    logic signed [10:0] y_next;
    logic signed [5:0]  vel_inc;
    logic signed [5:0]  vel_clip;
    logic [2:0]         f_mod;
    logic               unused_btn;

    assign upd        = bus.frame_tick & ~frame_q;
    assign right      = ~bus.buttons[0];
    assign left       = ~bus.buttons[1];
    assign up         = ~bus.buttons[3];
    assign unused_btn = ^{bus.buttons[7:4], bus.buttons[2]};

    // Horizontal move, shared by all states; collision checks use the moved x.
    always_comb begin
        x_wide  = {1'b0, x_q} + STEP_U;
        x_mv    = x_q;
        face_mv = facing_q;
        if (right && !left) begin
            x_mv    = (x_wide > X_MAX_U) ? X_MAX_U[9:0] : x_wide[9:0];
            face_mv = 1'b1;
        end else if (left && !right) begin
            x_mv    = ({1'b0, x_q} < STEP_U) ? 10'd0 : x_q - STEP_U[9:0];
            face_mv = 1'b0;
        end
    end

    assign overlap   = ({1'b0, x_mv} + CHAR_W_U > PLT_L_U) && ({1'b0, x_mv} < PLT_R_U);
    assign supported = (y_q == GROUND_S) || (PLAT_EN && (y_q == PLT_TOP_S) && overlap);
    assign gnd_state = (right ^ left) ? StWalk : StIdle;
    assign y_next    = y_q + {{5{vel_q[5]}}, vel_q};
    assign vel_inc   = vel_q + GRAV_S;
    assign vel_clip  = (vel_inc > MAXF_S) ? MAXF_S : vel_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StAir;
        end else if (upd) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_mv;
        facing_d = face_mv;
        y_d      = y_q;
        vel_d    = vel_q;
        unique case (state_q)
            StIdle, StWalk: begin
                if (up) begin
                    vel_d   = JUMP_S;
                    state_d = StAir;
                end else if (!supported) begin
                    vel_d   = '0;
                    state_d = StAir;
                end else begin
                    state_d = gnd_state;
                end
            end
            StAir: begin
                if (y_next[10]) begin
                    y_d   = '0;
                    vel_d = '0;
                end else if (PLAT_EN && (vel_q > 6'sd0) && overlap && (y_q <= PLT_TOP_S)
                             && (y_next >= PLT_TOP_S)) begin
                    y_d     = PLT_TOP_S;
                    vel_d   = '0;
                    state_d = gnd_state;
                end else if (y_next >= GROUND_S) begin
                    y_d     = GROUND_S;
                    vel_d   = '0;
                    state_d = gnd_state;
                end else begin
                    y_d   = y_next;
                    vel_d = vel_clip;
                end
            end
            default: state_d = StAir;
        endcase

        // The walk cycle only advances on frames spent entirely in WALK.
        f_d   = f_q;
        div_d = div_q;
        if (state_d != StWalk) begin
            f_d   = '0;
            div_d = '0;
        end else if (state_q == StWalk) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                f_d   = (f_q == 3'd5) ? 3'd0 : f_q + 3'd1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_comb begin
        f_mod = (f_d >= 3'd3) ? f_d - 3'd3 : f_d;
        row_d = '0;
        col_d = '0;
        unique case (state_d)
            StAir: row_d = 10'd30;
            StWalk: begin
                row_d = (f_d >= 3'd3) ? 10'd30 : 10'd0;
                unique case (f_mod)
                    3'd1:    col_d = 10'd23;
                    3'd2:    col_d = 10'd46;
                    default: col_d = 10'd0;
                endcase
            end
            default: ;
        endcase
        bus.on_ground = (state_q != StAir);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q  <= 1'b0;
            x_q      <= 10'(X_INIT);
            y_q      <= Y_INIT_S;
            vel_q    <= '0;
            facing_q <= 1'b1;
            f_q      <= '0;
            div_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            frame_q <= bus.frame_tick;
            if (upd) begin
                x_q      <= x_d;
                y_q      <= y_d;
                vel_q    <= vel_d;
                facing_q <= facing_d;
                f_q      <= f_d;
                div_q    <= div_d;
                row_q    <= row_d;
                col_q    <= col_d;
            end
        end
    end

    assign bus.char_x       = x_q;
    assign bus.char_y       = y_q[9:0];
    assign bus.facing_right = facing_q;
    assign bus.anim_row     = row_q;
    assign bus.anim_col     = col_q;

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: a frame-level reference model queues the expected outputs
// of every tick, plus fixed expectations at the notable points of each scenario.
module tb_player_motion;

`ifdef PLATFORM_COLLIDE_EN
    localparam bit PLAT = 1'b1;
`else
    localparam bit PLAT = 1'b0;
`endif

    localparam int XI = 3;
    localparam logic [7:0] NONE = 8'hFF;
    localparam logic [7:0] RGT  = 8'hFE;
    localparam logic [7:0] LFT  = 8'hFD;
    localparam logic [7:0] BOTH = 8'hFC;
    localparam logic [7:0] UP   = 8'hF7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    player_motion_if bus ();

    player_motion #(.X_INIT(XI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [41:0] sb[$];

    // Reference model state: st 0 idle, 1 walk, 2 air.
    int mx, my, mv, mst, mf, mdiv, mrow, mcol;
    bit mface;

    function automatic logic [41:0] obs();
        return {bus.char_x, bus.char_y, bus.facing_right, bus.anim_row, bus.anim_col,
                bus.on_ground};
    endfunction

    task automatic model_reset();
        mx = XI; my = 0; mv = 0; mst = 2; mf = 0; mdiv = 0; mrow = 0; mcol = 0; mface = 1'b1;
    endtask

    task automatic model_step(input logic [7:0] b, output logic [41:0] e);
        bit r, l, u, ov;
        int ns, gs, yn, vn, fm;
        r = !b[0]; l = !b[1]; u = !b[3];
        if (r && !l) begin
            mx = (mx + 5 > 610) ? 610 : mx + 5;
            mface = 1'b1;
        end else if (l && !r) begin
            mx = (mx < 5) ? 0 : mx - 5;
            mface = 1'b0;
        end
        ov = (mx + 46 > 100) && (mx < 200);
        gs = (r ^ l) ? 1 : 0;
        ns = mst;
        if (mst != 2) begin
            if (u) begin
                mv = -12; ns = 2;
            end else if (!(my == 440 || (PLAT && my == 350 && ov))) begin
                mv = 0; ns = 2;
            end else begin
                ns = gs;
            end
        end else begin
            yn = my + mv;
            vn = (mv + 1 > 10) ? 10 : mv + 1;
            if (yn < 0) begin
                my = 0; mv = 0;
            end else if (PLAT && mv > 0 && ov && my + 60 <= 410 && yn + 60 >= 410) begin
                my = 350; mv = 0; ns = gs;
            end else if (yn >= 440) begin
                my = 440; mv = 0; ns = gs;
            end else begin
                my = yn; mv = vn;
            end
        end
        if (ns != 1) begin
            mf = 0; mdiv = 0;
        end else if (mst == 1) begin
            if (mdiv == 3) begin
                mdiv = 0;
                mf = (mf == 5) ? 0 : mf + 1;
            end else begin
                mdiv++;
            end
        end
        mst = ns;
        fm = mf % 3;
        mrow = (mst == 2) ? 30 : (mst == 1 && mf >= 3) ? 30 : 0;
        mcol = (mst == 1) ? 23 * fm : 0;
        e = {10'(mx), 10'(my), mface, 10'(mrow), 10'(mcol), (mst != 2)};
    endtask

    // One frame: buttons valid only in the rising-edge cycle, noise on them afterwards.
    task automatic do_tick(input logic [7:0] b);
        logic [41:0] e;
        @(negedge clk);
        bus.buttons = b;
        bus.frame_tick = 1'b1;
        model_step(b, e);
        sb.push_back(e);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.buttons = 8'($urandom);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.frame_tick = 1'b0;
        bus.buttons = NONE;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs() !== {10'(XI), 10'd0, 1'b1, 10'd0, 10'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", obs(),
                     {10'(XI), 10'd0, 1'b1, 10'd0, 10'd0, 1'b0});
        end
        model_reset();
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_fall();
        logic [41:0] e;
        for (int i = 0; i < 60; i++) begin
            do_tick((i == 0) ? LFT : NONE);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL fall_tick%0d: got %h want %h", i, obs(), e);
            end
            if (i == 0) begin
                n_tests++;
                if (bus.char_x !== 10'd0 || bus.facing_right !== 1'b0) begin
                    n_fail++;
                    $display("FAIL left_clamp: got x=%0d face=%b want x=0 face=0",
                             bus.char_x, bus.facing_right);
                end
            end
        end
        n_tests++;
        if (bus.char_y !== 10'd440 || bus.on_ground !== 1'b1 || bus.anim_row !== 10'd0
            || bus.anim_col !== 10'd0) begin
            n_fail++;
            $display("FAIL fall_floor: got y=%0d og=%b row=%0d col=%0d want 440 1 0 0",
                     bus.char_y, bus.on_ground, bus.anim_row, bus.anim_col);
        end
    endtask

    task automatic test_walk_anim();
        logic [41:0] e;
        int cols[6] = '{0, 23, 46, 0, 23, 46};
        int rows[6] = '{0, 0, 0, 30, 30, 30};
        for (int i = 0; i < 28; i++) begin
            do_tick(RGT);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL walk_tick%0d: got %h want %h", i, obs(), e);
            end
            n_tests++;
            if (bus.anim_col !== 10'(cols[(i / 4) % 6]) || bus.anim_row !== 10'(rows[(i / 4) % 6]))
            begin
                n_fail++;
                $display("FAIL walk_anim%0d: got row=%0d col=%0d want row=%0d col=%0d", i,
                         bus.anim_row, bus.anim_col, rows[(i / 4) % 6], cols[(i / 4) % 6]);
            end
        end
        n_tests++;
        if (bus.char_x !== 10'd140) begin
            n_fail++;
            $display("FAIL walk_x: got %0d want 140", bus.char_x);
        end
    endtask

    task automatic test_both_pressed();
        logic [41:0] e;
        for (int i = 0; i < 3; i++) begin
            do_tick(BOTH);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL both_tick%0d: got %h want %h", i, obs(), e);
            end
        end
        n_tests++;
        if (obs() !== {10'd140, 10'd440, 1'b1, 10'd0, 10'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL both_idle: got %h want %h", obs(),
                     {10'd140, 10'd440, 1'b1, 10'd0, 10'd0, 1'b1});
        end
    endtask

    task automatic test_jump();
        logic [41:0] e;
        int land = -1;
        do_tick(UP);
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e || bus.on_ground !== 1'b0 || bus.char_y !== 10'd440) begin
            n_fail++;
            $display("FAIL jump_start: got %h want %h", obs(), e);
        end
        for (int i = 1; i <= 40; i++) begin
            do_tick(NONE);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL jump_tick%0d: got %h want %h", i, obs(), e);
            end
            if (i == 1) begin
                n_tests++;
                if (bus.char_y !== 10'd428) begin
                    n_fail++;
                    $display("FAIL jump_first_rise: got %0d want 428", bus.char_y);
                end
            end
            if (bus.on_ground === 1'b1) begin
                land = i;
                break;
            end
        end
        // 12 rising frames, 1 at the apex, 13 falling (1..9 then 10s) back to 440.
        n_tests++;
        if (land != 26 || bus.char_y !== 10'd440) begin
            n_fail++;
            $display("FAIL jump_land: got tick=%0d y=%0d want tick=26 y=440", land, bus.char_y);
        end
    endtask

    task automatic test_right_clamp();
        logic [41:0] e;
        int want[3] = '{605, 610, 610};
        for (int i = 0; i < 200 && bus.char_x !== 10'd600; i++) begin
            do_tick(RGT);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL to600_tick%0d: got %h want %h", i, obs(), e);
            end
        end
        n_tests++;
        if (bus.char_x !== 10'd600) begin
            n_fail++;
            $display("FAIL reach_600: got %0d want 600", bus.char_x);
        end
        for (int i = 0; i < 3; i++) begin
            do_tick(RGT);
            void'(sb.pop_front());
            n_tests++;
            if (bus.char_x !== 10'(want[i]) || bus.facing_right !== 1'b1) begin
                n_fail++;
                $display("FAIL right_clamp%0d: got x=%0d face=%b want x=%0d face=1", i,
                         bus.char_x, bus.facing_right, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid_jump();
        do_tick(UP);
        for (int i = 0; i < 7; i++) do_tick(NONE);
        sb.delete();
        n_tests++;
        if (bus.char_y !== 10'd377 || bus.on_ground !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_jump_y: got y=%0d og=%b want 377 0", bus.char_y, bus.on_ground);
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.frame_tick = 1'b1;
        bus.buttons = RGT;
        @(negedge clk);
        n_tests++;
        if (obs() !== {10'(XI), 10'd0, 1'b1, 10'd0, 10'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_jump: got %h want %h", obs(),
                     {10'(XI), 10'd0, 1'b1, 10'd0, 10'd0, 1'b0});
        end
        bus.frame_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        n_tests++;
        if (bus.char_x !== 10'(XI) || bus.char_y !== 10'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got x=%0d y=%0d want x=%0d y=0", bus.char_x,
                     bus.char_y, XI);
        end
    endtask

    task automatic test_held_tick();
        logic [41:0] e;
        @(negedge clk);
        bus.buttons = RGT;
        bus.frame_tick = 1'b1;
        model_step(RGT, e);
        sb.push_back(e);
        repeat (100) @(negedge clk);
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e || bus.char_x !== 10'(XI + 5)) begin
            n_fail++;
            $display("FAIL held_tick_once: got %h want %h", obs(), e);
        end
        bus.frame_tick = 1'b0;
        bus.buttons = NONE;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_platform_drop();
        logic [41:0] e;
        for (int i = 0; i < 60; i++) begin
            do_tick((i < 23) ? RGT : NONE);
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL drop_tick%0d: got %h want %h", i, obs(), e);
            end
        end
        for (int i = 0; i < 3; i++) do_tick(NONE);
        sb.delete();
        n_tests++;
        if (bus.char_x !== 10'd123 || bus.char_y !== (PLAT ? 10'd350 : 10'd440)
            || bus.on_ground !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_rest: got x=%0d y=%0d og=%b want x=123 y=%0d og=1",
                     bus.char_x, bus.char_y, bus.on_ground, PLAT ? 350 : 440);
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.buttons = NONE;
        model_reset();
        test_reset();
        test_fall();
        test_walk_anim();
        test_both_pressed();
        test_jump();
        test_right_clamp();
        test_reset_mid_jump();
        test_held_tick();
        test_platform_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
